// File: rtl/fp_mon_pkg.sv
// fp_mon_pkg: shared types, IEEE-754 field constants, MISR taps and helpers
// for the FPmul result monitor.
package fp_mon_pkg;

  // Result class of an IEEE-754 single-precision word (sign ignored).
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    SUB  = 3'd1,
    INF  = 3'd2,
    NAN  = 3'd3,
    NORM = 3'd4
  } fp_class_e;

  // Read handshake states.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rd_state_e;

  localparam int         NUM_CLASSES = 5;
  localparam int         EXP_MSB     = 30;
  localparam int         EXP_LSB     = 23;
  localparam int         MAN_W       = 23;
  localparam logic [7:0] EXP_ALL1    = 8'hFF;

  // MISR feedback taps.
  localparam int MISR_TAP_A = 31;
  localparam int MISR_TAP_B = 21;
  localparam int MISR_TAP_C = 1;
  localparam int MISR_TAP_D = 0;

  // Map a result word onto its class from the exponent/mantissa fields.
  function automatic fp_class_e fp_classify(input logic [31:0] z);
    logic [7:0]       e;
    logic [MAN_W-1:0] m;
    e = z[EXP_MSB:EXP_LSB];
    m = z[MAN_W-1:0];
    if (e == 8'h00) begin
      return (m == {MAN_W{1'b0}}) ? ZERO : SUB;
    end else if (e == EXP_ALL1) begin
      return (m == {MAN_W{1'b0}}) ? INF : NAN;
    end else begin
      return NORM;
    end
  endfunction

  // One MISR step: shift with XOR feedback, then fold in the new word.
  function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], s[MISR_TAP_A] ^ s[MISR_TAP_B] ^ s[MISR_TAP_C] ^ s[MISR_TAP_D]} ^ d;
  endfunction

endpackage

// File: rtl/fp_result_monitor_if.sv
// fp_result_monitor_if: capture strobe/data plus host read handshake.
interface fp_result_monitor_if;
  logic        EN;
  logic [31:0] FP_Z;
  logic        RD_REQ;
  logic        RD_ACK;
  logic [31:0] RD_DATA;
  logic        RD_EMPTY;

  modport master (output EN, output FP_Z, output RD_REQ,
                  input RD_ACK, input RD_DATA, input RD_EMPTY);
  modport slave  (input EN, input FP_Z, input RD_REQ,
                  output RD_ACK, output RD_DATA, output RD_EMPTY);
endinterface

// File: rtl/fp_mon_fifo.sv
// fp_mon_fifo: result buffer with wrap-bit pointers. A pop in the same cycle
// as a push to a full buffer frees the slot, so the push is accepted.
module fp_mon_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_r;
  logic [AW:0]  rptr_r;
  logic [W-1:0] mem_r [DEPTH];
  logic         rd_s;
  logic         wr_s;

  assign empty = (wptr_r == rptr_r);
  assign full  = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
  assign head  = mem_r[rptr_r[AW-1:0]];

  // Qualify pop/push against occupancy; pop makes room for a full push.
  always_comb begin
    rd_s = pop && !empty;
    wr_s = push && (!full || rd_s);
  end

  // Pointer advance on accepted operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_s) begin
        wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_s) begin
        rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents are meaningless until pointers cover them.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/fp_result_monitor.sv
// fp_result_monitor: classifies each captured FPmul result, keeps saturating
// per-class counters, buffers results for a req/ack host reader and records
// dropped captures. Optional MISR signature on SIG when
// FP_RESULT_MONITOR_SIG_EN is defined; otherwise SIG is tied to zero.
module fp_result_monitor
  import fp_mon_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  fp_result_monitor_if.slave bus,
  output logic               DROP,
  output logic [CNT_W-1:0]   CNT_ZERO,
  output logic [CNT_W-1:0]   CNT_SUB,
  output logic [CNT_W-1:0]   CNT_INF,
  output logic [CNT_W-1:0]   CNT_NAN,
  output logic [CNT_W-1:0]   CNT_NORM,
  output logic [31:0]        SIG
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fp_class_e              cls_s;
  logic [NUM_CLASSES-1:0] inc_s;
  logic [CNT_W-1:0]       cnt_r [NUM_CLASSES];
  rd_state_e              state_r;
  rd_state_e              state_nx_s;
  logic                   pop_s;
  logic                   empty_s;
  logic                   full_s;
  logic [31:0]            head_s;
  logic [31:0]            held_r;
  logic [31:0]            rd_data_r;
  logic                   rd_ack_r;
  logic                   drop_r;

  fp_mon_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (bus.EN),
    .pop   (pop_s),
    .wdata (bus.FP_Z),
    .head  (head_s),
    .empty (empty_s),
    .full  (full_s)
  );

  assign cls_s        = fp_classify(bus.FP_Z);
  assign bus.RD_ACK   = rd_ack_r;
  assign bus.RD_DATA  = rd_data_r;
  assign bus.RD_EMPTY = empty_s;
  assign DROP         = drop_r;
  assign CNT_ZERO     = cnt_r[0];
  assign CNT_SUB      = cnt_r[1];
  assign CNT_INF      = cnt_r[2];
  assign CNT_NAN      = cnt_r[3];
  assign CNT_NORM     = cnt_r[4];

  // One-hot select of the counter bumped by this capture.
  always_comb begin
    inc_s = 5'b00000;
    if (bus.EN) begin
      case (cls_s)
        ZERO:    inc_s = 5'b00001;
        SUB:     inc_s = 5'b00010;
        INF:     inc_s = 5'b00100;
        NAN:     inc_s = 5'b01000;
        NORM:    inc_s = 5'b10000;
        default: inc_s = 5'b00000;
      endcase
    end else begin
      inc_s = 5'b00000;
    end
  end

  // Saturating class counters: hold at all-ones instead of wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (inc_s[i] && (cnt_r[i] != CNT_MAX)) begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Sticky drop flag: a capture into a full buffer with no same-cycle pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_r <= 1'b0;
    end else if (bus.EN && full_s && !pop_s) begin
      drop_r <= 1'b1;
    end
  end

  // Read FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Read FSM next state; the pop happens on the IDLE->ACK transition.
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.RD_REQ && !empty_s) begin
          state_nx_s = ACK;
          pop_s      = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACK:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Hold the popped head, then present it together with the one-cycle ack.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      held_r    <= 32'h0000_0000;
      rd_data_r <= 32'h0000_0000;
      rd_ack_r  <= 1'b0;
    end else begin
      if (pop_s) begin
        held_r <= head_s;
      end
      if (state_r == ACK) begin
        rd_data_r <= held_r;
      end
      rd_ack_r <= (state_r == ACK);
    end
  end

`ifdef FP_RESULT_MONITOR_SIG_EN
  logic [31:0] sig_r;

  // MISR signature folding in every captured result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sig_r <= 32'h0000_0000;
    end else if (bus.EN) begin
      sig_r <= misr_next(sig_r, bus.FP_Z);
    end
  end

  assign SIG = sig_r;
`else
  assign SIG = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fp_result_monitor.sv
// tb_fp_result_monitor: directed stimulus against a queue-based reference
// model; every cycle the outputs are compared, plus literal spot checks.
module tb_fp_result_monitor;

  logic clk = 1'b0;
  logic rst;

  fp_result_monitor_if bus0();
  fp_result_monitor_if bus4();

  logic        drop0, drop4;
  logic [15:0] c0_zero, c0_sub, c0_inf, c0_nan, c0_norm;
  logic [3:0]  c4_zero, c4_sub, c4_inf, c4_nan, c4_norm;
  logic [31:0] sig0, sig4;

  assign bus4.EN     = bus0.EN;
  assign bus4.FP_Z   = bus0.FP_Z;
  assign bus4.RD_REQ = 1'b0;

  fp_result_monitor #(.DEPTH(16), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .bus(bus0.slave), .DROP(drop0),
    .CNT_ZERO(c0_zero), .CNT_SUB(c0_sub), .CNT_INF(c0_inf),
    .CNT_NAN(c0_nan), .CNT_NORM(c0_norm), .SIG(sig0)
  );

  fp_result_monitor #(.DEPTH(16), .CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .bus(bus4.slave), .DROP(drop4),
    .CNT_ZERO(c4_zero), .CNT_SUB(c4_sub), .CNT_INF(c4_inf),
    .CNT_NAN(c4_nan), .CNT_NORM(c4_norm), .SIG(sig4)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  int          m_cnt[5];
  int          m_cnt4[5];
  bit          m_ack = 1'b0;
  logic [31:0] m_data = 32'h0;
  bit          m_drop = 1'b0;
  logic [31:0] m_sig = 32'h0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_w = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  function automatic int fp_class(input logic [31:0] z);
    int e, m;
    e = int'((z >> 23) & 32'h0000_00FF);
    m = int'(z & 32'h007F_FFFF);
    if (e == 0) return (m == 0) ? 0 : 1;
    if (e == 255) return (m == 0) ? 2 : 3;
    return 4;
  endfunction

  task automatic model_step();
    bit grant;
    int k;
    if (rst) begin
      m_q.delete();
      m_ack = 1'b0; m_data = 32'h0; m_drop = 1'b0; m_sig = 32'h0;
      m_pend = 1'b0; m_pend_w = 32'h0;
      for (int i = 0; i < 5; i++) begin
        m_cnt[i] = 0; m_cnt4[i] = 0;
      end
    end else begin
      grant = !m_pend && (bus0.RD_REQ === 1'b1) && (m_q.size() > 0);
      if (m_pend) begin
        m_ack = 1'b1; m_data = m_pend_w; m_pend = 1'b0;
      end else begin
        m_ack = 1'b0;
      end
      if (grant) begin
        m_pend_w = m_q.pop_front();
        m_pend = 1'b1;
      end
      if (bus0.EN === 1'b1) begin
        k = fp_class(bus0.FP_Z);
        if (m_cnt[k] < 65535) m_cnt[k]++;
        if (m_cnt4[k] < 15) m_cnt4[k]++;
        if (m_q.size() < 16) m_q.push_back(bus0.FP_Z);
        else m_drop = 1'b1;
`ifdef FP_RESULT_MONITOR_SIG_EN
        m_sig = {m_sig[30:0], m_sig[31] ^ m_sig[21] ^ m_sig[1] ^ m_sig[0]} ^ bus0.FP_Z;
`endif
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      m_cnt[i] = 0; m_cnt4[i] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("rd_ack",   32'(bus0.RD_ACK),   32'(m_ack));
    chk("rd_data",  bus0.RD_DATA,       m_data);
    chk("rd_empty", 32'(bus0.RD_EMPTY), 32'(m_q.size() == 0));
    chk("drop",     32'(drop0),         32'(m_drop));
    chk("cnt_zero", 32'(c0_zero), 32'(m_cnt[0]));
    chk("cnt_sub",  32'(c0_sub),  32'(m_cnt[1]));
    chk("cnt_inf",  32'(c0_inf),  32'(m_cnt[2]));
    chk("cnt_nan",  32'(c0_nan),  32'(m_cnt[3]));
    chk("cnt_norm", 32'(c0_norm), 32'(m_cnt[4]));
    chk("sig",      sig0,         m_sig);
    chk("cnt4_zero", 32'(c4_zero), 32'(m_cnt4[0]));
    chk("cnt4_sub",  32'(c4_sub),  32'(m_cnt4[1]));
    chk("cnt4_inf",  32'(c4_inf),  32'(m_cnt4[2]));
    chk("cnt4_nan",  32'(c4_nan),  32'(m_cnt4[3]));
    chk("cnt4_norm", 32'(c4_norm), 32'(m_cnt4[4]));
  endtask

  // Advance one cycle: compare at the falling edge, return 1 ns after rising.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit en, input logic [31:0] z, input bit req);
    bus0.EN = en; bus0.FP_Z = z; bus0.RD_REQ = req;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic cap(input logic [31:0] w);
    set_in(1'b1, w, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b0);
  endtask

  // Wait (bounded) for an ack pulse after a request was issued.
  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (bus0.RD_ACK === 1'b1) got = 1'b1;
    end
  endtask

  task automatic read_chk(input logic [31:0] exp, input string nm);
    bit got;
    set_in(1'b0, 32'h0, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 1'b0);
    wait_ack(got);
    chk({nm, "_ack"}, 32'(got), 32'h1);
    chk(nm, bus0.RD_DATA, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0);
    do_reset();
    chk("reset_empty", 32'(bus0.RD_EMPTY), 32'h1);
    chk("reset_rd_data", bus0.RD_DATA, 32'h0);
    chk("reset_cnt_norm", 32'(c0_norm), 32'h0);

    // Test 1: one word of each class, then four ordered reads.
    cap(32'h3F80_0000); cap(32'h0000_0000); cap(32'h0000_0001);
    cap(32'h7F80_0000); cap(32'h7FC0_0000);
    tick();
    chk("t1_zero", 32'(c0_zero), 32'h1);
    chk("t1_sub",  32'(c0_sub),  32'h1);
    chk("t1_inf",  32'(c0_inf),  32'h1);
    chk("t1_nan",  32'(c0_nan),  32'h1);
    chk("t1_norm", 32'(c0_norm), 32'h1);
    read_chk(32'h3F80_0000, "t1_rd0");
    read_chk(32'h0000_0000, "t1_rd1");
    read_chk(32'h0000_0001, "t1_rd2");
    read_chk(32'h7F80_0000, "t1_rd3");
    chk("t1_not_empty", 32'(bus0.RD_EMPTY), 32'h0);

    // Test 2: overflow by one, drain, then a request on an empty buffer.
    do_reset();
    for (int i = 1; i <= 17; i++) cap(32'(i));
    tick();
    chk("t2_drop", 32'(drop0), 32'h1);
    for (int i = 1; i <= 16; i++) read_chk(32'(i), "t2_rd");
    set_in(1'b0, 32'h0, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 1'b0);
    wait_ack(got);
    chk("t2_no_ack", 32'(got), 32'h0);
    chk("t2_empty", 32'(bus0.RD_EMPTY), 32'h1);

    // Test 3: full buffer, pop and push in the same cycle.
    do_reset();
    for (int i = 0; i < 16; i++) cap(32'h100 + 32'(i));
    set_in(1'b1, 32'hABCD_0000, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 1'b0);
    wait_ack(got);
    chk("t3_ack", 32'(got), 32'h1);
    chk("t3_rd_first", bus0.RD_DATA, 32'h100);
    chk("t3_no_drop", 32'(drop0), 32'h0);
    for (int i = 1; i < 16; i++) read_chk(32'h100 + 32'(i), "t3_rd");
    read_chk(32'hABCD_0000, "t3_rd_last");
    chk("t3_empty", 32'(bus0.RD_EMPTY), 32'h1);

    // Test 4: counter saturation on the narrow instance.
    do_reset();
    for (int i = 0; i < 20; i++) cap(32'h4000_0000);
    tick(); tick(); tick();
    chk("t4_norm4_sat", 32'(c4_norm), 32'hF);
    chk("t4_norm16", 32'(c0_norm), 32'd20);

    // Test 5: signature after a single capture.
    do_reset();
    cap(32'h3F80_0000);
    tick();
`ifdef FP_RESULT_MONITOR_SIG_EN
    chk("t5_sig", sig0, 32'h3F80_0000);
`else
    chk("t5_sig", sig0, 32'h0);
`endif

    // Test 6: reset while the ack is high.
    do_reset();
    cap(32'h3F80_0000); cap(32'h4000_0000);
    set_in(1'b0, 32'h0, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 1'b0);
    wait_ack(got);
    chk("t6_ack_seen", 32'(got), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_ack_drop", 32'(bus0.RD_ACK), 32'h0);
    chk("t6_empty", 32'(bus0.RD_EMPTY), 32'h1);
    chk("t6_cnt_norm", 32'(c0_norm), 32'h0);
    do_reset();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
